// File: rtl/stepper_pkg.sv
// Shared constants, FSM encoding and helpers for the STEP/DIR decoder.
package stepper_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_MIN_HIGH    = 50;
  localparam int DEF_DIR_SETUP   = 10;

  localparam logic [31:0] SAT32 = 32'hFFFF_FFFF;

  typedef enum logic {
    S_LOW  = 1'b0,
    S_HIGH = 1'b1
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == SAT32) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/step_dir_decoder_if.sv
// Control/status bundle of the STEP/DIR decoder; master drives the inputs, slave is the decoder.
interface step_dir_decoder_if;
  import stepper_pkg::*;

  logic        enable;
  logic        step_in;
  logic        dir_in;
  logic        clear_pos;
  logic        err_clear;
  logic [31:0] position;
  logic [31:0] step_period;
  logic        period_valid;
  logic        step_event;
  logic        err_width;
  logic        err_setup;
  state_t      dbg_state;

  // No handshake: inputs are levels sampled every clk, step_event is a one-cycle pulse,
  // all other outputs are registered levels.
  modport master (
    output enable, step_in, dir_in, clear_pos, err_clear,
    input  position, step_period, period_valid, step_event, err_width, err_setup, dbg_state
  );

  modport slave (
    input  enable, step_in, dir_in, clear_pos, err_clear,
    output position, step_period, period_valid, step_event, err_width, err_setup, dbg_state
  );

endinterface

// File: rtl/sync_ff.sv
// Parameterized-depth single-bit synchronizer with asynchronous reset to 0.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sr <= '0;
    else       sr <= (sr << 1) | STAGES'(d);
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/step_dir_decoder.sv
// STEP/DIR decoder: synchronizes the lines, counts position, measures step period
// and flags pulse-width and DIR-setup violations.
module step_dir_decoder
  import stepper_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int MIN_HIGH    = DEF_MIN_HIGH,
  parameter int DIR_SETUP   = DEF_DIR_SETUP
) (
  input  logic              clk,
  input  logic              reset,
  step_dir_decoder_if.slave bus
);

  localparam logic [7:0] WARM = 8'(SYNC_STAGES);

  logic        step_s, dir_s, dir_q;
  logic [7:0]  warm_cnt;
  logic        primed;
  state_t      state;
  logic [31:0] pos_q, period_q, cnt_q, hi_cnt, dir_cnt;
  logic        armed, pvalid_q, event_q, hi_acc, errw_q, errs_q;

  logic warm_ok, rise, fall, accept, setup_viol, width_viol;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_step (
    .clk(clk), .reset(reset), .d(bus.step_in), .q(step_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_dir (
    .clk(clk), .reset(reset), .d(bus.dir_in), .q(dir_s)
  );

  // The synchronizer output is only trusted once it has been refilled after reset;
  // a rise additionally needs a genuine low seen first, so a pulse spanning reset is ignored.
  assign warm_ok    = (warm_cnt == WARM);
  assign rise       = (state == S_LOW) && step_s && primed;
  assign fall       = (state == S_HIGH) && !step_s;
  assign accept     = rise && bus.enable;
  assign setup_viol = accept && (dir_cnt < 32'(DIR_SETUP));
  assign width_viol = fall && hi_acc && (hi_cnt < 32'(MIN_HIGH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_LOW;
      warm_cnt <= '0;
      primed   <= 1'b0;
      dir_q    <= 1'b0;
      dir_cnt  <= '0;
      hi_cnt   <= '0;
      hi_acc   <= 1'b0;
      pos_q    <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      armed    <= 1'b0;
      pvalid_q <= 1'b0;
      event_q  <= 1'b0;
      errw_q   <= 1'b0;
      errs_q   <= 1'b0;
    end else begin
      if (warm_cnt != WARM) warm_cnt <= warm_cnt + 8'd1;
      if (warm_ok && !step_s) primed <= 1'b1;

      dir_q   <= dir_s;
      dir_cnt <= (dir_s != dir_q) ? 32'd1 : sat_inc(dir_cnt);

      case (state)
        S_LOW: if (rise) begin
          state  <= S_HIGH;
          hi_cnt <= 32'd1;
          hi_acc <= bus.enable;
        end
        S_HIGH: begin
          if (fall) state  <= S_LOW;
          else      hi_cnt <= sat_inc(hi_cnt);
        end
        default: state <= S_LOW;
      endcase

      event_q <= accept;
      if (bus.clear_pos)  pos_q <= '0;
      else if (accept)    pos_q <= dir_s ? pos_q + 32'd1 : pos_q - 32'd1;

      // Period measurement restarts whenever enable drops; the first accepted rise only arms it.
      if (!bus.enable) begin
        cnt_q    <= '0;
        armed    <= 1'b0;
        pvalid_q <= 1'b0;
      end else if (accept) begin
        if (armed) begin
          period_q <= cnt_q;
          pvalid_q <= 1'b1;
        end
        armed <= 1'b1;
        cnt_q <= 32'd1;
      end else if (armed) begin
        cnt_q <= sat_inc(cnt_q);
      end

      errw_q <= (errw_q & ~bus.err_clear) | width_viol;
      errs_q <= (errs_q & ~bus.err_clear) | setup_viol;
    end
  end

  assign bus.position     = pos_q;
  assign bus.step_period  = period_q;
  assign bus.period_valid = pvalid_q;
  assign bus.step_event   = event_q;
  assign bus.err_width    = errw_q;
  assign bus.err_setup    = errs_q;
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_step_dir_decoder.sv
// Directed bench for step_dir_decoder with hand-computed expectations (default parameters).
module tb_step_dir_decoder;
  import stepper_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ev_cnt  = 0;
  int   ev0;

  step_dir_decoder_if bus();

  step_dir_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / event counter
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.step_event === 1'b1) ev_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks (all return on a falling edge)
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int per);
    bus.step_in = 1'b1;
    idle(hi);
    bus.step_in = 1'b0;
    idle(per - hi);
  endtask

  task automatic clr_pos();
    bus.clear_pos = 1'b1;
    idle(1);
    bus.clear_pos = 1'b0;
  endtask

  task automatic clr_err();
    bus.err_clear = 1'b1;
    idle(1);
    bus.err_clear = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.enable    = 1'b1;
    bus.step_in   = 1'b0;
    bus.dir_in    = 1'b1;
    bus.clear_pos = 1'b0;
    bus.err_clear = 1'b0;
    idle(4);
    check("rst_position", bus.position, 32'd0);
    check("rst_period", bus.step_period, 32'd0);
    check("rst_pvalid", 32'(bus.period_valid), 32'd0);
    check("rst_event", 32'(bus.step_event), 32'd0);
    check("rst_errw", 32'(bus.err_width), 32'd0);
    check("rst_errs", 32'(bus.err_setup), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(S_LOW));
    reset = 1'b0;
    idle(20);

    // step_event exactly SYNC_STAGES+1 = 3 cycles after step_in rises
    @(negedge clk);
    bus.step_in = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("lat_early", 32'(bus.step_event), 32'd0);
    @(posedge clk); #1;
    check("lat_edge", 32'(bus.step_event), 32'd1);
    check("lat_pos", bus.position, 32'd1);
    idle(58);
    bus.step_in = 1'b0;
    idle(200);
    clr_pos();
    check("clr_pos", bus.position, 32'd0);

    // five pulses, 60 high, period 1000
    ev0 = ev_cnt;
    repeat (5) pulse(60, 1000);
    check("p5_position", bus.position, 32'd5);
    check("p5_period", bus.step_period, 32'd1000);
    check("p5_pvalid", 32'(bus.period_valid), 32'd1);
    check("p5_events", 32'(ev_cnt - ev0), 32'd5);
    check("p5_errw", 32'(bus.err_width), 32'd0);
    check("p5_errs", 32'(bus.err_setup), 32'd0);

    // decrement through zero, then signed wrap at the top
    clr_pos();
    bus.dir_in = 1'b0;
    idle(20);
    repeat (3) pulse(60, 200);
    check("dec_wrap", bus.position, 32'hFFFF_FFFD);
    bus.dir_in = 1'b1;
    idle(20);
    force dut.pos_q = 32'h7FFF_FFFF;
    idle(1);
    release dut.pos_q;
    idle(1);
    pulse(60, 200);
    check("inc_wrap", bus.position, 32'h8000_0000);

    // short pulse width and err_clear priority
    clr_err();
    clr_pos();
    pulse(20, 200);
    check("w_flag", 32'(bus.err_width), 32'd1);
    check("w_pos", bus.position, 32'd1);
    clr_err();
    check("w_cleared", 32'(bus.err_width), 32'd0);
    bus.step_in = 1'b1;
    idle(20);
    bus.step_in = 1'b0;
    idle(2);
    bus.err_clear = 1'b1;
    idle(1);
    bus.err_clear = 1'b0;
    check("w_clr_vs_viol", 32'(bus.err_width), 32'd1);
    check("w_pos2", bus.position, 32'd2);
    idle(200);

    // DIR setup: 4 cycles violates, 20 cycles does not
    clr_err();
    clr_pos();
    bus.dir_in = 1'b0;
    idle(4);
    pulse(60, 200);
    check("s_flag", 32'(bus.err_setup), 32'd1);
    check("s_pos", bus.position, 32'hFFFF_FFFF);
    clr_err();
    bus.dir_in = 1'b1;
    idle(20);
    pulse(60, 200);
    check("s_noflag", 32'(bus.err_setup), 32'd0);
    check("s_pos2", bus.position, 32'd0);

    // clear_pos in the same cycle as an accepted step
    pulse(60, 200);
    check("c_pre", bus.position, 32'd1);
    bus.step_in = 1'b1;
    idle(2);
    bus.clear_pos = 1'b1;
    idle(1);
    bus.clear_pos = 1'b0;
    check("c_event", 32'(bus.step_event), 32'd1);
    check("c_pos", bus.position, 32'd0);
    idle(57);
    bus.step_in = 1'b0;
    idle(200);

    // disabled pulses, then re-arm of the period measurement
    pulse(60, 200);
    check("e_pre_period", bus.step_period, 32'd260);
    ev0 = ev_cnt;
    bus.enable = 1'b0;
    idle(5);
    repeat (3) pulse(60, 300);
    check("e_off_pos", bus.position, 32'd1);
    check("e_off_pvalid", 32'(bus.period_valid), 32'd0);
    check("e_off_events", 32'(ev_cnt - ev0), 32'd0);
    check("e_off_period", bus.step_period, 32'd260);
    bus.enable = 1'b1;
    idle(5);
    pulse(60, 300);
    check("e_first_pvalid", 32'(bus.period_valid), 32'd0);
    check("e_first_pos", bus.position, 32'd2);
    pulse(60, 300);
    check("e_second_pvalid", 32'(bus.period_valid), 32'd1);
    check("e_second_period", bus.step_period, 32'd300);

    // enable rising while STEP already high
    bus.enable  = 1'b0;
    bus.step_in = 1'b1;
    idle(10);
    bus.enable = 1'b1;
    ev0 = ev_cnt;
    idle(60);
    bus.step_in = 1'b0;
    idle(50);
    check("en_high_events", 32'(ev_cnt - ev0), 32'd0);
    check("en_high_pos", bus.position, 32'd3);

    // reset during a STEP pulse
    bus.step_in = 1'b1;
    idle(10);
    reset = 1'b1;
    idle(5);
    check("r_mid_pos", bus.position, 32'd0);
    reset = 1'b0;
    ev0 = ev_cnt;
    idle(30);
    check("r_no_event", 32'(ev_cnt - ev0), 32'd0);
    check("r_state", 32'(bus.dbg_state), 32'(S_LOW));
    bus.step_in = 1'b0;
    idle(10);
    bus.step_in = 1'b1;
    idle(5);
    check("r_next_event", 32'(ev_cnt - ev0), 32'd1);
    check("r_next_pos", bus.position, 32'd1);
    idle(60);
    bus.step_in = 1'b0;
    idle(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
